// File: rtl/icb_mux_sel_ctrl.sv
// Select controller for a 1-master/5-slave ICB-ext mux: address decode, sel hold while beats
// are pending, and command/write-data gating. Optional local decode-error path: ICB_SEL_DECERR_EN.
module icb_mux_sel_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       LEN_W    = 8,
    parameter int unsigned       PEND_MAX = 64,
    parameter logic [ADDR_W-1:0] S0_BASE  = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] S1_BASE  = ADDR_W'(32'h1000_0000),
    parameter logic [ADDR_W-1:0] S2_BASE  = ADDR_W'(32'h2000_0000),
    parameter logic [ADDR_W-1:0] S3_BASE  = ADDR_W'(32'h3000_0000),
    parameter logic [ADDR_W-1:0] S4_BASE  = ADDR_W'(32'h4000_0000),
    parameter logic [ADDR_W-1:0] S0_MASK  = ADDR_W'(32'hF000_0000),
    parameter logic [ADDR_W-1:0] S1_MASK  = ADDR_W'(32'hF000_0000),
    parameter logic [ADDR_W-1:0] S2_MASK  = ADDR_W'(32'hF000_0000),
    parameter logic [ADDR_W-1:0] S3_MASK  = ADDR_W'(32'hF000_0000),
    parameter logic [ADDR_W-1:0] S4_MASK  = ADDR_W'(32'hF000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_cmd_valid,
    input  logic [ADDR_W-1:0] up_cmd_addr,
    input  logic              up_cmd_read,
    input  logic [LEN_W-1:0]  up_cmd_len,
    output logic              up_cmd_ready,
    output logic              dn_cmd_valid,
    input  logic              dn_cmd_ready,
    input  logic              up_w_valid,
    output logic              up_w_ready,
    output logic              dn_w_valid,
    input  logic              dn_w_ready,
    input  logic              mux_rsp_valid,
    input  logic              mux_rsp_err,
    input  logic [DATA_W-1:0] mux_rsp_rdata,
    output logic              mux_rsp_ready,
    output logic              up_rsp_valid,
    output logic              up_rsp_err,
    output logic [DATA_W-1:0] up_rsp_rdata,
    input  logic              up_rsp_ready,
    output logic [2:0]        sel,
    output logic              busy,
    output logic              proto_err
);
    localparam int unsigned CW = $clog2(PEND_MAX + 1);
    localparam int unsigned SW = CW + LEN_W + 1;
    localparam int unsigned EW = LEN_W + 1;
    localparam logic [4:0][ADDR_W-1:0] Bases = {S4_BASE, S3_BASE, S2_BASE, S1_BASE, S0_BASE};
    localparam logic [4:0][ADDR_W-1:0] Masks = {S4_MASK, S3_MASK, S2_MASK, S1_MASK, S0_MASK};

    typedef enum logic [1:0] {
        StIdle,
        StRoute
`ifdef ICB_SEL_DECERR_EN
        , StErrWr,
        StErrRsp
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   rsp_pend_q, rsp_pend_d, wr_pend_q, wr_pend_d;
    logic [2:0]      sel_q, sel_d;
    logic            busy_q, busy_d, proto_err_q, proto_err_d;
    logic [2:0]      dec_idx, sel_c;
    logic            dec_hit, drained, err_st, can_issue, fits, map_ok;
    logic            cmd_hs, w_hs, rsp_hs, stray, wr_open, rsp_open;
    logic [SW-1:0]   beats;
    logic            up_cmd_ready_c, dn_cmd_valid_c, up_w_ready_c, dn_w_valid_c;
    logic            mux_rsp_ready_c, up_rsp_valid_c;
`ifdef ICB_SEL_DECERR_EN
    logic [EW-1:0]   err_cnt_q, err_cnt_d, err_len_q, err_len_d;
    logic            dec_err_hs;
`else
    logic            unused_dec_hit;
    assign unused_dec_hit = dec_hit;
`endif

    // Lowest-numbered matching region wins.
    always_comb begin
        dec_idx = '0;
        dec_hit = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if ((up_cmd_addr & Masks[i]) == Bases[i]) begin
                dec_idx = 3'(i);
                dec_hit = 1'b1;
            end
        end
    end

    always_comb begin
        drained      = (rsp_pend_q == '0) && (wr_pend_q == '0);
        err_st       = 1'b0;
        map_ok       = 1'b1;
`ifdef ICB_SEL_DECERR_EN
        err_st       = (state_q == StErrWr) || (state_q == StErrRsp);
        map_ok       = dec_hit;
        dec_err_hs   = 1'b0;
        err_cnt_d    = err_cnt_q;
        err_len_d    = err_len_q;
`endif
        beats        = SW'(up_cmd_len) + SW'(1);
        fits         = (SW'(rsp_pend_q) + beats) <= SW'(PEND_MAX);
        can_issue    = !err_st && map_ok && (drained || (dec_idx == sel_q)) && fits;
        sel_c        = (drained && !err_st) ? dec_idx : sel_q;

        dn_cmd_valid_c  = up_cmd_valid & can_issue;
        up_cmd_ready_c  = dn_cmd_ready & can_issue;
        wr_open         = (wr_pend_q != '0);
        rsp_open        = (rsp_pend_q != '0);
        dn_w_valid_c    = up_w_valid & wr_open;
        up_w_ready_c    = dn_w_ready & wr_open;
        up_rsp_valid_c  = mux_rsp_valid & rsp_open;
        mux_rsp_ready_c = rsp_open ? up_rsp_ready : 1'b1;
        up_rsp_err      = mux_rsp_err;
        up_rsp_rdata    = mux_rsp_rdata;
        stray           = mux_rsp_valid & !rsp_open & !err_st;

`ifdef ICB_SEL_DECERR_EN
        // Unmapped command is swallowed locally, only from a fully drained idle state.
        if (!dec_hit && drained && (state_q == StIdle)) begin
            up_cmd_ready_c = 1'b1;
            dn_cmd_valid_c = 1'b0;
            dec_err_hs     = up_cmd_valid;
        end
        if (state_q == StErrWr) begin
            up_w_ready_c    = 1'b1;
            dn_w_valid_c    = 1'b0;
            mux_rsp_ready_c = 1'b0;
        end
        if (state_q == StErrRsp) begin
            up_rsp_valid_c  = 1'b1;
            up_rsp_err      = 1'b1;
            up_rsp_rdata    = '0;
            mux_rsp_ready_c = 1'b0;
        end
`endif

        cmd_hs = up_cmd_valid & up_cmd_ready_c & can_issue;
        w_hs   = up_w_valid & up_w_ready_c & wr_open;
        rsp_hs = mux_rsp_valid & mux_rsp_ready_c & rsp_open;

        // Single combined update so a same-cycle retire and issue cannot race.
        rsp_pend_d  = CW'(SW'(rsp_pend_q) + (cmd_hs ? beats : '0) - (rsp_hs ? SW'(1) : '0));
        wr_pend_d   = CW'(SW'(wr_pend_q) + ((cmd_hs && !up_cmd_read) ? beats : '0)
                          - (w_hs ? SW'(1) : '0));
        sel_d       = cmd_hs ? sel_c : sel_q;
        proto_err_d = proto_err_q | stray;

        state_d = state_q;
        unique case (state_q)
            StIdle, StRoute: begin
                state_d = ((rsp_pend_d == '0) && (wr_pend_d == '0)) ? StIdle : StRoute;
`ifdef ICB_SEL_DECERR_EN
                if (dec_err_hs) begin
                    state_d   = up_cmd_read ? StErrRsp : StErrWr;
                    err_cnt_d = EW'(beats);
                    err_len_d = EW'(beats);
                end
`endif
            end
`ifdef ICB_SEL_DECERR_EN
            StErrWr: begin
                if (up_w_valid) begin
                    if (err_cnt_q == EW'(1)) begin
                        state_d   = StErrRsp;
                        err_cnt_d = err_len_q;
                    end else begin
                        err_cnt_d = err_cnt_q - EW'(1);
                    end
                end
            end
            StErrRsp: begin
                if (up_rsp_ready) begin
                    if (err_cnt_q == EW'(1)) state_d = StIdle;
                    else                     err_cnt_d = err_cnt_q - EW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        busy_d = (rsp_pend_d != '0) || (wr_pend_d != '0);
`ifdef ICB_SEL_DECERR_EN
        busy_d = busy_d || (state_d == StErrWr) || (state_d == StErrRsp);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rsp_pend_q  <= '0;
            wr_pend_q   <= '0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
`ifdef ICB_SEL_DECERR_EN
            err_cnt_q   <= '0;
            err_len_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_pend_q  <= rsp_pend_d;
            wr_pend_q   <= wr_pend_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
`ifdef ICB_SEL_DECERR_EN
            err_cnt_q   <= err_cnt_d;
            err_len_q   <= err_len_d;
`endif
        end
    end

    // Handshake outputs are forced low while reset is asserted.
    assign up_cmd_ready  = rst_n & up_cmd_ready_c;
    assign dn_cmd_valid  = rst_n & dn_cmd_valid_c;
    assign up_w_ready    = rst_n & up_w_ready_c;
    assign dn_w_valid    = rst_n & dn_w_valid_c;
    assign mux_rsp_ready = rst_n & mux_rsp_ready_c;
    assign up_rsp_valid  = rst_n & up_rsp_valid_c;
    assign sel           = rst_n ? sel_c : 3'd0;
    assign busy          = busy_q;
    assign proto_err     = proto_err_q;

endmodule

// File: doc/icb_mux_sel_ctrl.md
Name: icb_mux_sel_ctrl

Overview:
Select controller for the 1-master/5-slave ICB-ext mux. Decodes each command address to a slave index and drives the mux `sel`. Holds `sel` stable while any write beats or response beats are still pending. Gates master command and write-data handshakes so traffic never switches slaves mid-transaction.

Parameters:
ADDR_W, 32, command address width
DATA_W, 32, response read-data width
LEN_W, 8, burst length field width (beats = len+1)
PEND_MAX, 64, max outstanding response beats (counter width = $clog2(PEND_MAX+1))
S0_BASE..S4_BASE, 0x0000_0000/0x1000_0000/0x2000_0000/0x3000_0000/0x4000_0000, slave region base
S0_MASK..S4_MASK, 0xF000_0000 each, region match mask

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
up_cmd_valid  in  1  master command valid
up_cmd_addr  in  ADDR_W  master command address
up_cmd_read  in  1  1=read, 0=write
up_cmd_len  in  LEN_W  burst length minus one
up_cmd_ready  out  1  command ready to master
dn_cmd_valid  out  1  gated command valid to mux
dn_cmd_ready  in  1  command ready from mux
up_w_valid  in  1  master write-data valid
up_w_ready  out  1  write-data ready to master
dn_w_valid  out  1  gated write-data valid to mux
dn_w_ready  in  1  write-data ready from mux
mux_rsp_valid  in  1  response valid from mux
mux_rsp_err  in  1  response error from mux
mux_rsp_rdata  in  DATA_W  response data from mux
mux_rsp_ready  out  1  response ready to mux
up_rsp_valid  out  1  response valid to master
up_rsp_err  out  1  response error to master
up_rsp_rdata  out  DATA_W  response data to master
up_rsp_ready  in  1  response ready from master
sel  out  3  mux select, 0..4
busy  out  1  any beats pending
proto_err  out  1  sticky: response seen with nothing pending

Behaviour:
- Reset (async, rst_n=0): sel_q=0, rsp_pend=0, wr_pend=0, state=IDLE, proto_err=0. All valid/ready outputs are 0 while in reset.
- Decode: dec_idx = lowest i with (addr & Si_MASK)==Si_BASE. If no region matches, the address is unmapped.
- drained = (rsp_pend==0 && wr_pend==0). `sel` = drained ? dec_idx : sel_q, so decode is combinational only while drained.
- can_issue = (drained || dec_idx==sel_q) && (rsp_pend + len + 1 <= PEND_MAX).
- dn_cmd_valid = up_cmd_valid & can_issue. up_cmd_ready = dn_cmd_ready & can_issue.
- On command handshake: sel_q <= sel. rsp_pend += len+1. If write, wr_pend += len+1.
- Write data: dn_w_valid = up_w_valid & (wr_pend!=0); up_w_ready = dn_w_ready & (wr_pend!=0). Each w handshake decrements wr_pend. A write beat in the same cycle as its own command handshake is not accepted; the earliest accepted beat is the cycle after the command handshake.
- Response: pass-through with rsp_ready = up_rsp_ready when rsp_pend!=0. Each handshake decrements rsp_pend.
- Simultaneous command and response handshake: rsp_pend = rsp_pend + len + 1 - 1, computed in a single update.
- mux_rsp_valid while rsp_pend==0: mux_rsp_ready=1 (response dropped), up_rsp_valid=0, proto_err set and held until reset.
- busy = !drained, registered, 0 after reset.
- States: IDLE (drained) -> ROUTE on command handshake; ROUTE -> IDLE when both counters reach 0 in the same update.
- Reset mid-burst clears all counters immediately. sel returns to 0.

Optional Feature:
ICB_SEL_DECERR_EN
- Defined: an unmapped command is accepted only when drained. up_cmd_ready=1 and dn_cmd_valid=0.
  - Next state: ERR_WR for writes, ERR_RSP for reads.
  - ERR_WR: up_w_ready=1 and dn_w_valid=0 for len+1 beats, then ERR_RSP.
  - ERR_RSP: drives len+1 local responses with up_rsp_err=1 and rdata=0, then IDLE.
  - In ERR states: up_cmd_ready=0, mux_rsp_ready=0, busy=1.
- Undefined: unmapped addresses route to slave 0. No ERR states exist.

Test Plan:
- Read addr 0x2000_0010, len=3, rsp_ready=1 -> sel=2; 4 responses; rsp_pend 4->0; busy falls the cycle after the 4th response.
- Write to 0x1000_0000, len=1, then a read to 0x3000_0000 issued immediately -> read held with dn_cmd_valid=0 until 2 w beats and 2 responses complete; then sel=3.
- Two back-to-back reads to 0x0000_0100, len=0, with slave 0 holding both responses -> both commands accepted; rsp_pend=2; sel stays 0.
- PEND_MAX=4, outstanding 3 beats, new command len=1 -> up_cmd_ready=0 until one response retires.
- Response and command handshake in the same cycle (rsp_pend=2, len=2) -> rsp_pend=4.
- ICB_SEL_DECERR_EN, read 0x9000_0000 len=1 -> dn_cmd_valid never set; 2 responses with err=1 and rdata=0. Without the macro -> sel=0 and the command is forwarded.
